toggle_count_sequencer: RTL and testbench

Sequencer for a WIDTH-bit bank of toggle flip-flops. It generates the per-bit toggle-enable vector each cycle, so that the bank behaves as a programmable modulo up/down counter. It also runs a start/pause/clear/done state machine around the counter and counts completed wrap rounds. The block holds a shadow of the bank state (`count`) and sits between the top-level control logic and the TFF datapath: the bank's T inputs are driven from `t_vec`.

---
 rtl/toggle_count_sequencer.sv | 153 +++++++++++++++
 tb/tb_toggle_count_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/toggle_count_sequencer.sv
// Toggle-enable sequencer for a WIDTH-bit TFF bank: programmable modulo up/down
// counter with start/pause/clear/done control and a completed-round counter.
module toggle_count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             up,
    input  logic [WIDTH-1:0] modulo,
    input  logic [7:0]       rounds,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Highest count value in range; a modulo of zero stands for 2^WIDTH.
    function automatic logic [WIDTH-1:0] top_value(input logic [WIDTH-1:0] m);
        return (m == ZERO) ? ONES : (m - ONE);
    endfunction

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] count_r, count_next_s, mod_r, last_s;
    logic [7:0]       rounds_r, round_cnt_r, round_next_s;
    logic             up_r, wrap_r, busy_r, done_r;
    logic             wrap_next_s, capture_s;

    // Next-state, next-count and round bookkeeping in priority order clear > start > pause > step.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        round_next_s = round_cnt_r;
        wrap_next_s  = 1'b0;
        capture_s    = 1'b0;
        last_s       = top_value(mod_r);
        if (clear) begin
            state_next_s = IDLE;
            count_next_s = ZERO;
            round_next_s = 8'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        capture_s    = 1'b1;
                        round_next_s = 8'd0;
                        count_next_s = up ? ZERO : top_value(modulo);
                        state_next_s = RUN;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next_s = PAUSE;
                    end else begin
                        if (up_r) begin
                            if (count_r == last_s) begin
                                count_next_s = ZERO;
                                wrap_next_s  = 1'b1;
                            end else begin
                                count_next_s = count_r + ONE;
                            end
                        end else begin
                            if (count_r == ZERO) begin
                                count_next_s = last_s;
                                wrap_next_s  = 1'b1;
                            end else begin
                                count_next_s = count_r - ONE;
                            end
                        end
                        // Finishing the programmed number of rounds ends the run on the wrapping edge.
                        if (wrap_next_s) begin
                            round_next_s = round_cnt_r + 8'd1;
                            if ((rounds_r != 8'd0) && (round_next_s == rounds_r)) begin
                                state_next_s = DONE;
                            end else begin
                                state_next_s = RUN;
                            end
                        end else begin
                            state_next_s = RUN;
                        end
                    end
                end
                PAUSE: begin
                    if (pause) begin
                        state_next_s = PAUSE;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    count_next_s = ZERO;
                    round_next_s = 8'd0;
                end
            endcase
        end
    end

    assign t_vec = count_r ^ count_next_s;

    // State, shadow count, captured run parameters and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            count_r     <= ZERO;
            round_cnt_r <= 8'd0;
            wrap_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            up_r        <= 1'b1;
            mod_r       <= ZERO;
            rounds_r    <= 8'd0;
        end else begin
            state_r     <= state_next_s;
            count_r     <= count_next_s;
            round_cnt_r <= round_next_s;
            wrap_r      <= wrap_next_s;
            busy_r      <= (state_next_s == RUN) || (state_next_s == PAUSE);
            done_r      <= (state_next_s == DONE);
            if (capture_s) begin
                up_r     <= up;
                mod_r    <= modulo;
                rounds_r <= rounds;
            end else begin
                up_r     <= up_r;
                mod_r    <= mod_r;
                rounds_r <= rounds_r;
            end
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_toggle_count_sequencer.sv
// Directed bench for toggle_count_sequencer (WIDTH = 4) with hand-computed
// expectations and a per-cycle count/t_vec consistency check.
module tb_toggle_count_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic       up = 1'b1;
    logic [3:0] modulo = 4'd0;
    logic [7:0] rounds = 8'd0;
    logic [3:0] t_vec, count;
    logic       wrap, busy, done;

    int checks = 0;
    int errors = 0;

    toggle_count_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .up(up), .modulo(modulo), .rounds(rounds),
        .t_vec(t_vec), .count(count), .wrap(wrap), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input logic [3:0] c, input logic w, input logic b, input logic d);
        check({tag, "_count"}, {28'd0, count}, {28'd0, c});
        check({tag, "_wrap"},  {31'd0, wrap},  {31'd0, w});
        check({tag, "_busy"},  {31'd0, busy},  {31'd0, b});
        check({tag, "_done"},  {31'd0, done},  {31'd0, d});
    endtask

    // Per-cycle invariant: count after an edge equals count ^ t_vec before it (reset edges excluded).
    logic       rst_at_edge = 1'b1;
    logic       have_prev = 1'b0;
    logic [3:0] prev_count, prev_t;
    always @(posedge clk) rst_at_edge = reset;
    always @(negedge clk) begin
        if (have_prev && !rst_at_edge)
            check("invariant", {28'd0, count}, {28'd0, prev_count ^ prev_t});
        prev_count = count;
        prev_t     = t_vec;
        have_prev  = 1'b1;
    end

    initial begin
        // Reset
        tick(); tick();
        reset = 1'b0;
        status("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        check("reset_tvec", {28'd0, t_vec}, 32'd0);

        // Up, modulo 5, 2 rounds
        up = 1'b1; modulo = 4'd5; rounds = 8'd2; start = 1'b1;
        #1 check("up_start_tvec", {28'd0, t_vec}, 32'd0);
        tick(); start = 1'b0;
        status("up_load", 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            if (count == 4'd3) check("up_tvec_3to4", {28'd0, t_vec}, 32'h7);
            if (count == 4'd4) check("up_tvec_4to0", {28'd0, t_vec}, 32'h4);
            tick();
            status("up_step", 4'(i % 5), (i % 5) == 0, i != 10, i == 10);
        end
        check("done_tvec", {28'd0, t_vec}, 32'd0);
        tick();
        status("done_hold", 4'd0, 1'b0, 1'b0, 1'b1);

        // Down, modulo 0 (16), 1 round
        up = 1'b0; modulo = 4'd0; rounds = 8'd1; start = 1'b1;
        #1 check("dn_start_tvec", {28'd0, t_vec}, 32'hF);
        tick(); start = 1'b0;
        status("dn_load", 4'd15, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            status("dn_step", 4'(15 - i), 1'b0, 1'b1, 1'b0);
        end
        check("dn_wrap_tvec", {28'd0, t_vec}, 32'hF);
        tick();
        status("dn_wrap", 4'd15, 1'b1, 1'b0, 1'b1);

        // Pause at 6, up modulo 10, free-run
        up = 1'b1; modulo = 4'd10; rounds = 8'd0; start = 1'b1;
        tick(); start = 1'b0;
        status("pz_load", 4'd0, 1'b0, 1'b1, 1'b0);
        repeat (6) tick();
        status("pz_at6", 4'd6, 1'b0, 1'b1, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) pause = 1'b0;
            #1 check("pz_tvec", {28'd0, t_vec}, 32'd0);
            tick();
            status("pz_hold", 4'd6, 1'b0, 1'b1, 1'b0);
        end
        check("pz_resume_tvec", {28'd0, t_vec}, 32'h1);
        tick();
        status("pz_resume", 4'd7, 1'b0, 1'b1, 1'b0);

        // Clear while paused at 9
        tick(); tick();
        pause = 1'b1;
        tick();
        status("clr_paused", 4'd9, 1'b0, 1'b1, 1'b0);
        clear = 1'b1;
        #1 check("clr_tvec", {28'd0, t_vec}, 32'h9);
        tick(); clear = 1'b0; pause = 1'b0;
        status("clr_after", 4'd0, 1'b0, 1'b0, 1'b0);

        // Start and clear together while running: clear wins
        start = 1'b1;
        tick(); start = 1'b0;
        repeat (3) tick();
        status("sc_at3", 4'd3, 1'b0, 1'b1, 1'b0);
        start = 1'b1; clear = 1'b1;
        #1 check("sc_tvec", {28'd0, t_vec}, 32'h3);
        tick(); start = 1'b0; clear = 1'b0;
        status("sc_after", 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        status("sc_idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // Modulo 1, 3 rounds
        up = 1'b1; modulo = 4'd1; rounds = 8'd3; start = 1'b1;
        #1 check("m1_start_tvec", {28'd0, t_vec}, 32'd0);
        tick(); start = 1'b0;
        status("m1_load", 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            check("m1_tvec", {28'd0, t_vec}, 32'd0);
            tick();
            status("m1_step", 4'd0, 1'b1, i != 3, i == 3);
        end
        tick();
        status("m1_done", 4'd0, 1'b0, 1'b0, 1'b1);

        // Reset mid-run at 3, then a fresh run
        modulo = 4'd10; rounds = 8'd0; start = 1'b1;
        tick(); start = 1'b0;
        repeat (3) tick();
        status("rs_at3", 4'd3, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        tick(); reset = 1'b0;
        status("rs_after", 4'd0, 1'b0, 1'b0, 1'b0);
        check("rs_tvec", {28'd0, t_vec}, 32'd0);
        modulo = 4'd5; rounds = 8'd1; start = 1'b1;
        tick(); start = 1'b0;
        status("rs_load", 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            status("rs_step", 4'(i % 5), i == 5, i != 5, i == 5);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
